// File: rtl/lfsr_pkg.sv
// Shared constants for the serial-to-byte deserializer: byte width, frame lengths, bit counter width.
package lfsr_pkg;

  localparam int BYTE_W        = 8;
  localparam int FRAME_LEN     = 8;
  localparam int FRAME_LEN_PAR = 9;
  localparam int BIT_CNT_W     = 4;

  function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/lfsr_sync_fifo.sv
// Single-clock FIFO with level output; zero-latency head, push accepted when full only alongside a pop.
// Head data reads 0 while empty; clear flushes pointers and level in one cycle.
module lfsr_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic              push_acc,
  output logic [DATA_W-1:0] head_dat,
  output logic              not_empty,
  output logic [LVL_W-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              empty, full, pop_acc;

  always_comb begin
    empty     = (level_q == '0);
    full      = (level_q == LVL_W'(DEPTH));
    pop_acc   = pop && !empty && !clear;
    push_acc  = push && !clear && (!full || pop_acc);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // When full, wr_ptr equals rd_ptr: the popped slot is refilled in the same cycle.
      if (push_acc) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_acc && !pop_acc) begin
        level_d = level_q + 1'b1;
      end else if (pop_acc && !push_acc) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head_dat  = empty ? '0 : mem_q[rd_ptr_q];
  assign not_empty = !empty;
  assign level     = level_q;

endmodule

// File: rtl/lfsr_deser.sv
// Serial (LSB-first) to byte deserializer feeding a small FIFO; push on the last frame bit, valid/ready pop.
// Optional feature LFSR_DESER_PARITY_EN: 9-bit frames with an even-parity bit, error flag stored per entry.
module lfsr_deser
  import lfsr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_in,
  input  logic              ser_valid,
  input  logic              clear,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic              perr
);

`ifdef LFSR_DESER_PARITY_EN
  localparam int FRAME_BITS = FRAME_LEN_PAR;
  localparam int ENTRY_W    = BYTE_W + 1;
`else
  localparam int FRAME_BITS = FRAME_LEN;
  localparam int ENTRY_W    = BYTE_W;
`endif

  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    shreg_q, shreg_d;
  logic                 overflow_q, overflow_d;
  logic                 push, push_acc, last_bit;
  logic [ENTRY_W-1:0]   push_dat, head_dat;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    last_bit  = (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));
`ifdef LFSR_DESER_PARITY_EN
    push_dat  = {byte_parity(shreg_q) ^ ser_in, shreg_q};
`else
    push_dat  = {ser_in, shreg_q[BYTE_W-2:0]};
`endif
    if (clear) begin
      bit_cnt_d = '0;
      shreg_d   = '0;
    end else if (ser_valid) begin
      // The parity bit position (8) falls outside the shift register and is only used at push time.
      if (bit_cnt_q < BIT_CNT_W'(BYTE_W)) begin
        shreg_d[bit_cnt_q[$clog2(BYTE_W)-1:0]] = ser_in;
      end
      if (last_bit) begin
        push      = 1'b1;
        bit_cnt_d = '0;
        shreg_d   = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (clear) begin
      overflow_d = 1'b0;
    end else if (push && !push_acc) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      overflow_q <= overflow_d;
    end
  end

  lfsr_sync_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .push_dat  (push_dat),
    .pop       (data_ready),
    .push_acc  (push_acc),
    .head_dat  (head_dat),
    .not_empty (data_valid),
    .level     (fifo_level)
  );

  assign data_out = head_dat[BYTE_W-1:0];
  assign overflow = overflow_q;
`ifdef LFSR_DESER_PARITY_EN
  assign perr = head_dat[BYTE_W];
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_deser.sv
// Directed self-checking bench for lfsr_deser: framing, FIFO full/overflow, reset and clear behaviour.
module tb_lfsr_deser;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             ser_in;
  logic             ser_valid;
  logic             clear;
  logic [7:0]       data_out;
  logic             data_valid;
  logic             data_ready;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic             perr;

  int n_checks = 0;
  int n_fails  = 0;

  lfsr_deser #(.FIFO_DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .clear      (clear),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .perr       (perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic rdy);
    ser_in     = b;
    ser_valid  = 1'b1;
    data_ready = rdy;
    tick();
    ser_in     = 1'b0;
    ser_valid  = 1'b0;
    data_ready = 1'b0;
  endtask

  // Sends one full frame; pop_last raises data_ready on the frame's final bit.
  task automatic send_byte(input logic [7:0] b, input logic pop_last);
`ifdef LFSR_DESER_PARITY_EN
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit(^b, pop_last);
`else
    for (int i = 0; i < 7; i++) send_bit(b[i], 1'b0);
    send_bit(b[7], pop_last);
`endif
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, data_valid, 1);
    chk({tag, "_data"}, data_out, exp);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; clear = 1'b0; data_ready = 1'b0;
    #12;
    chk("rst_valid", data_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", data_out, 0);
    chk("rst_perr", perr, 0);
    #5 rst = 1'b1;
    tick();

    // Scenario 1: A5, LSB first
    begin
      logic [7:0] v;
      v = 8'hA5;
`ifdef LFSR_DESER_PARITY_EN
      for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0);
      chk("s1_valid_early", data_valid, 0);
      send_bit(^v, 1'b0);
`else
      for (int i = 0; i < 7; i++) send_bit(v[i], 1'b0);
      chk("s1_valid_early", data_valid, 0);
      send_bit(v[7], 1'b0);
`endif
    end
    chk("s1_level", fifo_level, 1);
    chk("s1_perr", perr, 0);
    pop_expect("s1", 8'hA5);
    chk("s1_level_after", fifo_level, 0);
    chk("s1_empty_data", data_out, 0);

    // Scenario 2: fill past full, overflow, drain in order, pop on empty ignored
    for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b0);
    chk("s2_level4", fifo_level, 4);
    chk("s2_no_ovf", overflow, 0);
    send_byte(8'h05, 1'b0);
    chk("s2_level_full", fifo_level, 4);
    chk("s2_ovf", overflow, 1);
    tick();
    chk("s2_head_stable", data_out, 8'h01);
    pop_expect("s2_p1", 8'h01);
    pop_expect("s2_p2", 8'h02);
    pop_expect("s2_p3", 8'h03);
    pop_expect("s2_p4", 8'h04);
    chk("s2_empty", data_valid, 0);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    chk("s2_pop_empty_level", fifo_level, 0);
    chk("s2_ovf_sticky", overflow, 1);

    // Scenario 3: push into full FIFO with simultaneous pop
    do_clear();
    chk("s3_clr_ovf", overflow, 0);
    for (int k = 0; k < 4; k++) send_byte(8'h10 + 8'(k), 1'b0);
    send_byte(8'h3C, 1'b1);
    chk("s3_no_ovf", overflow, 0);
    chk("s3_level", fifo_level, 4);
    pop_expect("s3_p1", 8'h11);
    pop_expect("s3_p2", 8'h12);
    pop_expect("s3_p3", 8'h13);
    pop_expect("s3_p4", 8'h3C);
    chk("s3_empty", fifo_level, 0);

    // Scenario 4: reset mid-frame
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    rst = 1'b0;
    #3;
    chk("s4_rst_level", fifo_level, 0);
    rst = 1'b1;
    tick();
    send_byte(8'hF0, 1'b0);
    chk("s4_level", fifo_level, 1);
    pop_expect("s4", 8'hF0);

`ifdef LFSR_DESER_PARITY_EN
    // Scenario 5: parity error flag
    begin
      logic [7:0] v;
      v = 8'h07;
      for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0);
      send_bit(1'b0, 1'b0);
      chk("s5_perr1", perr, 1);
      pop_expect("s5_a", 8'h07);
      for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0);
      send_bit(1'b1, 1'b0);
      chk("s5_perr0", perr, 0);
      pop_expect("s5_b", 8'h07);
    end
`endif

    // Scenario 6: clear with level 3, overflow set, 5 bits pending; clear beats ser_valid and data_ready
    for (int k = 1; k <= 5; k++) send_byte(8'h20 + 8'(k), 1'b0);
    pop_expect("s6_pre", 8'h21);
    chk("s6_level3", fifo_level, 3);
    chk("s6_ovf_set", overflow, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    clear = 1'b1; ser_valid = 1'b1; ser_in = 1'b1; data_ready = 1'b1;
    tick();
    clear = 1'b0; ser_valid = 1'b0; ser_in = 1'b0; data_ready = 1'b0;
    chk("s6_level0", fifo_level, 0);
    chk("s6_ovf0", overflow, 0);
    chk("s6_valid0", data_valid, 0);
    chk("s6_data0", data_out, 0);
    send_byte(8'h5A, 1'b0);
    chk("s6_level1", fifo_level, 1);
    pop_expect("s6_post", 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lfsr_deser.md
LFSR_DESER -- requirements
Module: lfsr_deser

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of byte entries buffered; SHALL be a power of two, 2..16.
REQ-002 Parameter LVL_W, default $clog2(FIFO_DEPTH)+1, width of fifo_level.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ser_in  input  1  serial data bit, LSB of each byte first.
REQ-006 ser_valid  input  1  ser_in SHALL be sampled on every rising clk edge where ser_valid=1.
REQ-007 clear  input  1  synchronous flush of the frame counter, FIFO and flags.
REQ-008 data_out  output  8  head-of-FIFO byte.
REQ-009 data_valid  output  1  high while the FIFO is non-empty.
REQ-010 data_ready  input  1  consumer accept; a pop occurs when data_valid=1 and data_ready=1.
REQ-011 fifo_level  output  LVL_W  number of stored bytes, 0..FIFO_DEPTH.
REQ-012 overflow  output  1  sticky; a completed byte was dropped.
REQ-013 perr  output  1  parity-error flag travelling with the head byte.

Function
REQ-014 Each sampled bit SHALL be written to the shift position given by bit_cnt (0..7): the first bit goes to bit 0 and the eighth to bit 7.
REQ-015 On the eighth data bit, the assembled byte SHALL be pushed in the same cycle; with the FIFO previously empty, data_valid SHALL rise on the next cycle.
REQ-016 bit_cnt SHALL wrap to 0 after each frame; bits SHALL be held indefinitely while ser_valid=0, with no timeout.
REQ-017 A push SHALL be accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
REQ-018 Otherwise the byte SHALL be discarded and overflow SHALL be set, held until clear or reset; FIFO contents SHALL be unchanged.
REQ-019 data_out and perr SHALL remain stable while data_valid=1 and data_ready=0.
REQ-020 data_out and perr SHALL read 0 when the FIFO is empty.
REQ-021 A pop on an empty FIFO SHALL be ignored.
REQ-022 fifo_level SHALL change as follows: +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-023 clear=1 SHALL zero bit_cnt, the partial byte, the FIFO pointers, fifo_level and overflow in one cycle.
REQ-024 clear SHALL take priority over ser_valid and data_ready in the same cycle; the sampled bit is lost.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by fifo_level.

Reset
REQ-026 rst=0 SHALL asynchronously clear all of the following: bit_cnt, partial byte, FIFO pointers, storage, fifo_level, overflow, data_valid, data_out and perr.
REQ-027 Reset asserted mid-frame SHALL discard the partial byte; the first bit after release SHALL be treated as bit 0.

Configuration
REQ-028 With LFSR_DESER_PARITY_EN defined, a frame SHALL be 9 bits: 8 data bits followed by an even-parity bit.
REQ-029 With the macro defined, the push SHALL occur on the 9th bit, and perr SHALL be stored as (XOR of data bits) XOR (parity bit) alongside the byte; the byte SHALL be stored regardless of perr.
REQ-030 Without the macro, frames SHALL be 8 bits, no per-entry perr storage SHALL exist, and perr SHALL be tied to 0.

Structure
REQ-031 Package lfsr_pkg SHALL hold BYTE_W=8 and the frame-length constants (8, and 9 with parity); lfsr_deser SHALL import it.
REQ-032 Storage SHALL be one sub-module, lfsr_sync_fifo (data width parameterised, depth FIFO_DEPTH, level output), instantiated once.
REQ-033 The framing and bit counter SHALL live in lfsr_deser.

Verification
REQ-034 Scenario 1: with no parity, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> data_out=8'hA5, data_valid=1 one cycle after the 8th bit, fifo_level=1.
REQ-035 Scenario 2: FIFO_DEPTH=4, data_ready=0, five bytes 8'h01..8'h05 -> fifo_level=4, overflow=1 after the 5th byte; pops return 01,02,03,04.
REQ-036 Scenario 3: full FIFO, data_ready=1 in the same cycle the 8th bit of 8'h3C arrives -> no overflow, fifo_level stays 4, 8'h3C is the last entry popped.
REQ-037 Scenario 4: 3 bits sent, then rst pulsed low, then 8'hF0 sent -> data_out=8'hF0, fifo_level=1.
REQ-038 Scenario 5: with LFSR_DESER_PARITY_EN, 8'h07 followed by parity bit 0 -> perr=1; 8'h07 followed by parity bit 1 -> perr=0.
REQ-039 Scenario 6: clear asserted with fifo_level=3, overflow=1, bit_cnt=5 -> next cycle fifo_level=0, overflow=0, data_valid=0, and the next bit is treated as bit 0.
